// File: rtl/conv_frame_encoder_if.sv
// Stream bundle for the rate-1/2 frame encoder: info-bit input stream,
// code-symbol output stream and the frame-complete pulse.
interface conv_frame_encoder_if;
  logic       in_valid_sig;
  logic       in_ready_sig;
  logic       in_bit_sig;
  logic       out_valid_sig;
  logic       out_ready_sig;
  logic [1:0] out_sym_sig;
  logic       out_last_sig;
  logic       frame_done_sig;

  modport master (
    output in_valid_sig, in_bit_sig, out_ready_sig,
    input  in_ready_sig, out_valid_sig, out_sym_sig, out_last_sig, frame_done_sig
  );

  modport slave (
    input  in_valid_sig, in_bit_sig, out_ready_sig,
    output in_ready_sig, out_valid_sig, out_sym_sig, out_last_sig, frame_done_sig
  );
endinterface

// File: rtl/conv_frame_encoder.sv
// Rate-1/2 feed-forward convolutional encoder: FRAME_LEN info bits per frame,
// then K-1 zero-input tail symbols so every frame ends in trellis state 0.
module conv_frame_encoder #(
  parameter int unsigned    FRAME_LEN = 2048,
  parameter int unsigned    K         = 3,
  parameter logic [K-1:0]   G0        = 'b111,
  parameter logic [K-1:0]   G1        = 'b101
) (
  input logic                 clk_sig,
  input logic                 reset_sig,
  conv_frame_encoder_if.slave bus
);
  localparam int unsigned   CW        = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned   TW        = (K > 2) ? $clog2(K - 1) : 1;
  localparam logic [CW-1:0] LAST_BIT  = CW'(FRAME_LEN - 1);
  localparam logic [TW-1:0] LAST_TAIL = TW'(K - 2);

  typedef enum logic {ST_DATA = 1'b0, ST_TAIL = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [TW-1:0] tail_cnt_q, tail_cnt_d;
  logic [K-2:0]  sr_q, sr_d;
  logic [1:0]    sym_q, sym_d;
  logic          out_valid_q, out_valid_d;
  logic          last_q, last_d;
  logic          done_q, done_d;

  logic          slot_free, in_ready, accept, tail_load, last_tail, enc_bit;
  logic [K-1:0]  r_vec;

  // State register
  always_ff @(posedge clk_sig or posedge reset_sig) begin
    if (reset_sig) begin
      state_q     <= ST_DATA;
      bit_cnt_q   <= '0;
      tail_cnt_q  <= '0;
      sr_q        <= '0;
      sym_q       <= '0;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      tail_cnt_q  <= tail_cnt_d;
      sr_q        <= sr_d;
      sym_q       <= sym_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
      done_q      <= done_d;
    end
  end

  // Output / handshake decode
  always_comb begin
    slot_free = !out_valid_q || bus.out_ready_sig;
    in_ready  = !reset_sig && (state_q == ST_DATA) && slot_free;
    accept    = bus.in_valid_sig && in_ready;
    tail_load = (state_q == ST_TAIL) && slot_free;
    last_tail = (tail_cnt_q == LAST_TAIL);
    // Tail symbols encode a forced zero input
    enc_bit   = accept && bus.in_bit_sig;
    r_vec     = {enc_bit, sr_q};
  end

  // Next-state
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    tail_cnt_d  = tail_cnt_q;
    sr_d        = sr_q;
    sym_d       = sym_q;
    out_valid_d = out_valid_q;
    last_d      = last_q;
    done_d      = out_valid_q && bus.out_ready_sig && last_q;

    if (accept || tail_load) begin
      sym_d       = {^(r_vec & G0), ^(r_vec & G1)};
      sr_d        = r_vec[K-1:1];
      out_valid_d = 1'b1;
      last_d      = tail_load && last_tail;
    end else if (bus.out_ready_sig) begin
      out_valid_d = 1'b0;
      last_d      = 1'b0;
    end

    case (state_q)
      ST_DATA: begin
        if (accept) begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = ST_TAIL;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      ST_TAIL: begin
        if (tail_load) begin
          if (last_tail) begin
            tail_cnt_d = '0;
            state_d    = ST_DATA;
          end else begin
            tail_cnt_d = tail_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_DATA;
    endcase
  end

  assign bus.in_ready_sig   = in_ready;
  assign bus.out_valid_sig  = out_valid_q;
  assign bus.out_sym_sig    = sym_q;
  assign bus.out_last_sig   = last_q;
  assign bus.frame_done_sig = done_q;
endmodule

// File: tb/tb_conv_frame_encoder.sv
// Directed and randomised checks of conv_frame_encoder: a FRAME_LEN=4 instance
// for hand-computed frames, a default instance against a reference encoder.
module tb_conv_frame_encoder;
  logic clk_sig   = 1'b0;
  logic reset_sig = 1'b1;
  always #5 clk_sig = ~clk_sig;

  conv_frame_encoder_if ia ();
  conv_frame_encoder_if ib ();

  conv_frame_encoder #(.FRAME_LEN(4)) dut_a (
    .clk_sig  (clk_sig),
    .reset_sig(reset_sig),
    .bus      (ia.slave)
  );

  conv_frame_encoder dut_b (
    .clk_sig  (clk_sig),
    .reset_sig(reset_sig),
    .bus      (ib.slave)
  );

  int total = 0;
  int bad   = 0;

  logic [1:0] sym_log[$];
  logic       last_log[$];
  logic       rdy_log[$];
  logic       acc;
  logic       hold_a;
  logic [1:0] held_sym;
  logic       held_last;

  localparam logic [11:0] EXP_1011 = 12'b11_10_00_01_01_11;
  localparam logic [11:0] EXP_1111 = 12'b11_01_10_10_01_11;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of dut_a: inputs applied after the falling edge, outputs sampled 1ns later.
  task automatic cyc_a(input logic v, input logic b, input logic r);
    @(negedge clk_sig);
    if (hold_a) begin
      chk("hold_valid", ia.out_valid_sig, 1);
      chk("hold_sym", ia.out_sym_sig, held_sym);
      chk("hold_last", ia.out_last_sig, held_last);
    end
    ia.in_valid_sig  = v;
    ia.in_bit_sig    = b;
    ia.out_ready_sig = r;
    #1;
    rdy_log.push_back(ia.in_ready_sig);
    acc = v && ia.in_ready_sig;
    if (ia.out_valid_sig && r) begin
      sym_log.push_back(ia.out_sym_sig);
      last_log.push_back(ia.out_last_sig);
    end
    hold_a    = ia.out_valid_sig && !r;
    held_sym  = ia.out_sym_sig;
    held_last = ia.out_last_sig;
  endtask

  // Feed one 4-bit frame (first bit in bits[3]) with out_ready low for cycles st..st+sl-1.
  task automatic run_frame_a(input string tag, input logic [3:0] bits, input logic [11:0] exp,
                             input int st, input int sl);
    int i     = 0;
    int cyc   = 0;
    int dones = 0;
    sym_log.delete();
    last_log.delete();
    rdy_log.delete();
    while (sym_log.size() < 6 && cyc < 40) begin
      cyc_a(i < 4, (i < 4) ? bits[3-i] : 1'b0, !(cyc >= st && cyc < st + sl));
      if (ia.frame_done_sig) dones++;
      if (acc) i++;
      cyc++;
    end
    chk({tag, "_nsym"}, sym_log.size(), 6);
    chk({tag, "_nbits"}, i, 4);
    chk({tag, "_early_done"}, dones, 0);
    for (int k = 0; k < sym_log.size() && k < 6; k++) begin
      chk($sformatf("%s_sym%0d", tag, k), sym_log[k], exp[11-2*k -: 2]);
      chk($sformatf("%s_last%0d", tag, k), last_log[k], k == 5);
    end
    cyc_a(1'b0, 1'b0, 1'b1);
    chk({tag, "_done"}, ia.frame_done_sig, 1);
    chk({tag, "_drained"}, ia.out_valid_sig, 0);
    cyc_a(1'b0, 1'b0, 1'b1);
    chk({tag, "_done_off"}, ia.frame_done_sig, 0);
  endtask

  initial begin
    logic       h1, h2, v, b, r;
    logic [1:0] e;
    logic [1:0] exp_q[$];
    int         nsym, nacc, cyc;

    ia.in_valid_sig = 0; ia.in_bit_sig = 0; ia.out_ready_sig = 0;
    ib.in_valid_sig = 0; ib.in_bit_sig = 0; ib.out_ready_sig = 0;
    hold_a = 0; held_sym = 0; held_last = 0; acc = 0;

    // Reset state
    #3;
    chk("rst_valid", ia.out_valid_sig, 0);
    chk("rst_sym", ia.out_sym_sig, 0);
    chk("rst_last", ia.out_last_sig, 0);
    chk("rst_done", ia.frame_done_sig, 0);
    chk("rst_ready", ia.in_ready_sig, 0);
    @(negedge clk_sig);
    reset_sig = 0;
    #1;
    chk("rel_ready_a", ia.in_ready_sig, 1);
    chk("rel_ready_b", ib.in_ready_sig, 1);

    // Test 1: plain frame, no backpressure
    run_frame_a("t1", 4'b1011, EXP_1011, 99, 0);
    for (int k = 0; k < 4; k++) chk($sformatf("t1_rdy%0d", k), rdy_log[k], 1);
    chk("t1_rdy_tail0", rdy_log[4], 0);
    chk("t1_rdy_tail1", rdy_log[5], 0);
    chk("t1_rdy_back", rdy_log[6], 1);

    // Test 2: out_ready low for 3 cycles mid-frame
    run_frame_a("t2", 4'b1011, EXP_1011, 2, 3);
    for (int k = 2; k < 5; k++) chk($sformatf("t2_rdy_stall%0d", k), rdy_log[k], 0);

    // Test 3: two consecutive all-ones frames
    run_frame_a("t3a", 4'b1111, EXP_1111, 99, 0);
    run_frame_a("t3b", 4'b1111, EXP_1111, 99, 0);

    // Test 4a: reset during TAIL
    cyc_a(1'b1, 1'b1, 1'b1);
    cyc_a(1'b1, 1'b0, 1'b1);
    cyc_a(1'b1, 1'b1, 1'b1);
    cyc_a(1'b1, 1'b1, 1'b1);
    @(negedge clk_sig);
    ia.in_valid_sig = 0;
    chk("t4_pre_valid", ia.out_valid_sig, 1);
    chk("t4_pre_ready", ia.in_ready_sig, 0);
    #2 reset_sig = 1;
    #1;
    chk("t4_rst_valid", ia.out_valid_sig, 0);
    chk("t4_rst_last", ia.out_last_sig, 0);
    chk("t4_rst_done", ia.frame_done_sig, 0);
    hold_a = 0;
    @(negedge clk_sig);
    reset_sig = 0;
    for (int k = 0; k < 3; k++) begin
      cyc_a(1'b0, 1'b0, 1'b1);
      chk("t4_no_tail", ia.out_valid_sig, 0);
      chk("t4_no_done", ia.frame_done_sig, 0);
    end
    run_frame_a("t4", 4'b1011, EXP_1011, 99, 0);

    // Test 4b: reset during DATA after two bits; counter must restart
    cyc_a(1'b1, 1'b1, 1'b1);
    cyc_a(1'b1, 1'b1, 1'b1);
    @(negedge clk_sig);
    ia.in_valid_sig = 0;
    #2 reset_sig = 1;
    #1;
    chk("t4b_rst_valid", ia.out_valid_sig, 0);
    hold_a = 0;
    @(negedge clk_sig);
    reset_sig = 0;
    run_frame_a("t4b", 4'b1011, EXP_1011, 99, 0);

    // Test 5: default frame length, random valid/ready, reference encoder model
    h1 = 0; h2 = 0; nsym = 0; nacc = 0; cyc = 0;
    while (nsym < 2050 && cyc < 30000) begin
      v = (nacc < 2048) && ($urandom_range(0, 3) != 0);
      b = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 3) != 0);
      @(negedge clk_sig);
      ib.in_valid_sig  = v;
      ib.in_bit_sig    = b;
      ib.out_ready_sig = r;
      #1;
      if (ib.out_valid_sig && r) begin
        if (exp_q.size() == 0) begin
          chk("t5_unexpected_sym", 0, 1);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("t5_sym%0d", nsym), ib.out_sym_sig, e);
        end
        chk($sformatf("t5_last%0d", nsym), ib.out_last_sig, nsym == 2049);
        nsym++;
      end
      if (v && ib.in_ready_sig) begin
        exp_q.push_back({b ^ h1 ^ h2, b ^ h2});
        h2 = h1; h1 = b;
        nacc++;
        if (nacc == 2048) begin
          exp_q.push_back({h1 ^ h2, h2});
          h2 = h1; h1 = 1'b0;
          exp_q.push_back({h1 ^ h2, h2});
          h2 = 1'b0;
        end
      end
      cyc++;
    end
    chk("t5_nsym", nsym, 2050);
    chk("t5_nacc", nacc, 2048);
    @(negedge clk_sig);
    ib.in_valid_sig  = 1;
    ib.in_bit_sig    = 1;
    ib.out_ready_sig = 1;
    #1;
    chk("t5_done", ib.frame_done_sig, 1);
    chk("t5_wrap_ready", ib.in_ready_sig, 1);
    @(negedge clk_sig);
    ib.in_valid_sig = 0;
    #1;
    chk("t5_wrap_valid", ib.out_valid_sig, 1);
    chk("t5_wrap_sym", ib.out_sym_sig, 2'b11);
    chk("t5_wrap_last", ib.out_last_sig, 0);
    chk("t5_done_off", ib.frame_done_sig, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
